// File: rtl/nf_bp_pkg.sv
// Shared definitions for the branch unit: funct3 codes, direction-counter states,
// the BTB entry layout and the saturating counter step.
package nf_bp_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // Widest tag any legal DEPTH/TAG_W pair can need; narrower tags sit in the low bits.
  localparam int BTB_TAG_MAX = 29;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    logic [31:0]            target;
    logic [1:0]             cnt;
  } btb_entry_t;

  function automatic logic br_type_legal(input logic [2:0] t);
    return t[2:1] != 2'b01;
  endfunction

  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
    logic [1:0] n;
    n = c;
    if (taken && c != CNT_ST) n = c + 2'd1;
    else if (!taken && c != CNT_SNT) n = c - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/nf_branch_cmp.sv
// Pure combinational RV32I branch condition evaluator; reserved funct3 codes give cond = 0.
module nf_branch_cmp
  import nf_bp_pkg::*;
(
  input  logic [2:0]  br_type,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  output logic        cond
);

  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_BEQ:  cond = (d0 == d1);
      BR_BNE:  cond = (d0 != d1);
      BR_BLT:  cond = ($signed(d0) <  $signed(d1));
      BR_BGE:  cond = ($signed(d0) >= $signed(d1));
      BR_BLTU: cond = (d0 <  d1);
      BR_BGEU: cond = (d0 >= d1);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/nf_branch_unit_bp.sv
// Branch resolution plus direct-mapped BTB with 2-bit direction counters.
// Define NF_BP_STATS_EN to add the br_cnt / mis_cnt statistics outputs.
module nf_branch_unit_bp
  import nf_bp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_if,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        br_valid,
  input  logic [2:0]  br_type,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  input  logic [31:0] pc_ex,
  input  logic [31:0] target_ex,
  input  logic        pred_taken_ex,
  input  logic [31:0] pred_target_ex,
  output logic        pc_src,
  output logic        mispredict,
`ifdef NF_BP_STATS_EN
  output logic [31:0] br_cnt,
  output logic [31:0] mis_cnt,
`endif
  output logic [31:0] redirect_pc
);

  localparam int IDX_W = $clog2(DEPTH);

  btb_entry_t btb_q [DEPTH];
  btb_entry_t entry_d;
  btb_entry_t if_entry;
  btb_entry_t ex_entry;
  logic       wr_en;
  logic       cond;
  logic       ex_hit;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] if_tag;
  logic [TAG_W-1:0] ex_tag;
  logic             unused_pc_bits;

  assign if_idx = pc_if[IDX_W+1:2];
  assign ex_idx = pc_ex[IDX_W+1:2];
  assign if_tag = pc_if[IDX_W+2 +: TAG_W];
  assign ex_tag = pc_ex[IDX_W+2 +: TAG_W];
  assign unused_pc_bits = ^{pc_if, pc_ex};

  nf_branch_cmp u_cmp (
    .br_type (br_type),
    .d0      (d0),
    .d1      (d1),
    .cond    (cond)
  );

  assign pc_src      = br_valid & cond;
  assign mispredict  = br_valid & ((pc_src != pred_taken_ex) |
                                   (pc_src & (pred_target_ex != target_ex)));
  assign redirect_pc = pc_src ? target_ex : pc_ex + 32'd4;

  // Fetch lookup reads the registered table only, so same-cycle training is never visible.
  assign if_entry    = btb_q[if_idx];
  assign pred_taken  = !reset && if_entry.valid &&
                       (if_entry.tag[TAG_W-1:0] == if_tag) && if_entry.cnt[1];
  assign pred_target = pred_taken ? if_entry.target : 32'd0;

  assign ex_entry = btb_q[ex_idx];
  assign ex_hit   = ex_entry.valid && (ex_entry.tag[TAG_W-1:0] == ex_tag);

  always_comb begin
    wr_en   = 1'b0;
    entry_d = ex_entry;
    if (br_valid && br_type_legal(br_type)) begin
      if (ex_hit) begin
        wr_en       = 1'b1;
        entry_d.cnt = cnt_next(ex_entry.cnt, pc_src);
        if (pc_src) entry_d.target = target_ex;
      end else if (pc_src) begin
        // Miss and taken: evict whatever lives at this index.
        wr_en          = 1'b1;
        entry_d.valid  = 1'b1;
        entry_d.tag    = BTB_TAG_MAX'(ex_tag);
        entry_d.target = target_ex;
        entry_d.cnt    = CNT_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        btb_q[i].valid  <= 1'b0;
        btb_q[i].tag    <= '0;
        btb_q[i].target <= '0;
        btb_q[i].cnt    <= CNT_WNT;
      end
    end else if (wr_en) begin
      btb_q[ex_idx] <= entry_d;
    end
  end

`ifdef NF_BP_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mis_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (br_valid)   br_cnt_q  <= br_cnt_q + 32'd1;
      if (mispredict) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;
`endif

endmodule

// File: doc/nf_branch_unit_bp.md
# nf_branch_unit_bp

Parametrised successor to the single-mode branch comparator. It resolves all six RV32I conditional branches (beq, bne, blt, bge, bltu, bge u) and adds a direct-mapped branch target buffer with 2-bit saturating direction counters. The BTB is looked up combinationally from the fetch PC and trained synchronously at execute. The block sits between fetch (prediction) and execute (resolution and redirect), and raises a mispredict flush with the corrected PC.

## Interface
Parameters:
- DEPTH, 16: number of BTB entries; power of two, ≥ 2. IDX_W = $clog2(DEPTH).
- TAG_W, 8: tag width; IDX_W + 2 + TAG_W ≤ 32.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- pc_if  input  32  fetch-stage PC
- pred_taken  output  1  fetch prediction: branch taken
- pred_target  output  32  fetch predicted target; 0 when pred_taken = 0
- br_valid  input  1  execute holds a branch; one-cycle pulse per instruction, already stall-qualified
- br_type  input  3  funct3 of the branch
- d0  input  32  rs1 value
- d1  input  32  rs2 value
- pc_ex  input  32  PC of the branch in execute
- target_ex  input  32  computed branch target (pc_ex + imm)
- pred_taken_ex  input  1  pred_taken piped to execute
- pred_target_ex  input  32  pred_target piped to execute
- pc_src  output  1  actual outcome: taken
- mispredict  output  1  flush request
- redirect_pc  output  32  correct next PC

## Operation
- Address split: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+2 +: TAG_W].
- Each entry holds: valid, tag, target[31:0], cnt[1:0].
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Updates saturate at 00 and 11.
- Prediction: pred_taken = valid & tag match & cnt[1] at idx(pc_if). pred_target = stored target when pred_taken, else 0.
- Compare by br_type:
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010 and 011 are illegal: cond = 0.
- pc_src = br_valid & cond.
- mispredict = br_valid & ((pc_src != pred_taken_ex) | (pc_src & pred_target_ex != target_ex)).
- redirect_pc = pc_src ? target_ex : pc_ex + 4, wrapping mod 2^32. It is meaningful only when mispredict = 1.
- Training, on the clock edge with br_valid = 1 and a legal br_type:
  - Hit: cnt increments if taken, decrements if not. If taken, target is overwritten with target_ex.
  - Miss and taken: allocate (valid = 1, tag, target_ex, cnt = 10), replacing any previous occupant.
  - Miss and not taken: no write.
- Illegal br_type: no table write. mispredict still follows the formula above, so a predicted-taken illegal entry redirects to pc_ex + 4.

## Timing
- Prediction, compare, mispredict and redirect_pc are combinational: zero latency.
- The table updates on the edge after br_valid; a lookup in the same cycle sees the old contents (no bypass).
- Lookup and update to the same idx in one cycle: the read returns the pre-update entry, and the write completes.
- During reset, all valid bits clear and all cnt become 01 in one cycle.
  - Outputs while reset = 1 and after: pred_taken = 0, pred_target = 0.
  - pc_src, mispredict and redirect_pc depend only on their inputs and are not reset.
  - A br_valid asserted together with reset is not trained; reset wins.
- br_valid held high for N cycles trains N times; de-duplicating is the pipeline's job.

## Configuration
- NF_BP_STATS_EN defined: adds output ports br_cnt[31:0] and mis_cnt[31:0].
  - br_cnt increments on every br_valid cycle; mis_cnt increments on every mispredict cycle.
  - Both reset to 0, wrap at 2^32 → 0, and do not count while reset = 1.
- Not defined: neither port nor counter exists; behaviour is otherwise identical.

## Structure
- Shared package nf_bp_pkg holds:
  - branch funct3 localparams BR_BEQ … BR_BGEU;
  - counter-state localparams CNT_SNT, CNT_WNT, CNT_WT, CNT_ST;
  - a packed typedef for the BTB entry.
- Sub-module nf_branch_cmp is a pure combinational comparator: br_type, d0, d1 → cond. It is reusable elsewhere in the codebase.

## Test plan
- Reset, then pc_if = 0x100 → pred_taken = 0, pred_target = 0.
- br_valid, br_type = 000, d0 = d1 = 5, pc_ex = 0x100, target_ex = 0x140, pred_taken_ex = 0 → pc_src = 1, mispredict = 1, redirect_pc = 0x140. Next cycle pc_if = 0x100 → pred_taken = 1, pred_target = 0x140.
- Signedness: d0 = 0xFFFFFFFF, d1 = 1:
  - br_type 100 → taken; 110 → not taken;
  - 101 → not taken; 111 → taken.
- Train the same hit entry taken three times, then not taken once:
  - cnt goes 10 → 11 → 11 → 10, and pred_taken stays 1;
  - a second not-taken → cnt 01, pred_taken = 0.
- Aliasing: pc 0x100 allocated, then a taken branch at 0x100 + 4·DEPTH·2^0 with a different tag → entry replaced, and a lookup of 0x100 misses.
- br_type = 010 with pred_taken_ex = 1, pc_ex = 0x200 → pc_src = 0, mispredict = 1, redirect_pc = 0x204, no table change. With NF_BP_STATS_EN defined, br_cnt and mis_cnt both increment by 1.
